lock_range_sweep: RTL and testbench

LOCK_RANGE_SWEEP -- requirements
Module: lock_range_sweep

---
 rtl/adpll_pkg.sv | 29 ++
 rtl/err_peak_detect.sv | 32 +++
 rtl/lock_range_sweep.sv | 165 ++++++++++++++++
 tb/tb_lock_range_sweep.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL lock-range sweeper.
// Holds the sweep FSM state encoding and the saturating absolute value.
package adpll_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_EVAL,
      ST_DONE
   } state_t;

   // |v| for a w-bit signed value; the most-negative code maps to the
   // largest positive code so the result still fits in w bits.
   function automatic logic [31:0] sat_abs(
      input logic signed [31:0] v,
      input int                 w
   );
      logic signed [31:0] v_min;
      v_min = -(32'sd1 <<< (w - 1));
      if (v == v_min)
         sat_abs = $unsigned((32'sd1 <<< (w - 1)) - 32'sd1);
      else if (v < 0)
         sat_abs = $unsigned(-v);
      else
         sat_abs = $unsigned(v);
   endfunction

endpackage

// File: rtl/err_peak_detect.sv
// Peak |phase error| tracker for one observation window.
// Clear has priority; samples only fold in while enabled.
module err_peak_detect
   import adpll_pkg::*;
#(
   parameter int ERR_WIDTH = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_clr,
   input  logic                        i_en,
   input  logic signed [ERR_WIDTH-1:0] i_err,
   output logic        [ERR_WIDTH-1:0] o_peak
);

   logic [ERR_WIDTH-1:0] w_abs;
   logic [ERR_WIDTH-1:0] r_peak;

   assign w_abs  = ERR_WIDTH'(sat_abs(32'(i_err), ERR_WIDTH));
   assign o_peak = r_peak;

   // Running maximum of |error|, restarted by clear
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_peak <= '0;
      else if (i_clr)
         r_peak <= '0;
      else if (i_en && (w_abs > r_peak))
         r_peak <= w_abs;
   end

endmodule

// File: rtl/lock_range_sweep.sv
// Steps the tuning word across [k_min, k_max], settling and measuring
// the ADPLL at each step, and reports the first contiguous lock range.
module lock_range_sweep
   import adpll_pkg::*;
#(
   parameter int K_WIDTH       = 12,
   parameter int ERR_WIDTH     = 8,
   parameter int SETTLE_CYCLES = 4096,
   parameter int WINDOW_CYCLES = 256,
   parameter int LOCK_THRESH   = 2
) (
   input  logic                        fpga_clk_i,
   input  logic                        rst_n_i,
   input  logic                        start_i,
   input  logic                        abort_i,
   input  logic        [K_WIDTH-1:0]   k_min_i,
   input  logic        [K_WIDTH-1:0]   k_max_i,
   input  logic signed [ERR_WIDTH-1:0] error_i,
   output logic        [K_WIDTH-1:0]   k_val_o,
   output logic                        pll_enable_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        found_o,
   output logic        [K_WIDTH-1:0]   lock_lo_o,
   output logic        [K_WIDTH-1:0]   lock_hi_o
);

   localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ?
                            SETTLE_CYCLES : WINDOW_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [K_WIDTH-1:0]   r_kmax;
   logic [K_WIDTH-1:0]   r_kval;
   logic                 r_pll;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_found;
   logic [K_WIDTH-1:0]   r_lo;
   logic [K_WIDTH-1:0]   r_hi;

   logic [ERR_WIDTH-1:0] w_peak;
   logic                 w_clr;
   logic                 w_en;
   logic                 w_locked;
   logic                 w_stop;

   assign w_clr    = (r_state == ST_SETTLE);
   assign w_en     = (r_state == ST_MEASURE);
   assign w_locked = (w_peak <= ERR_WIDTH'(LOCK_THRESH));
   assign w_stop   = (!w_locked && r_found) || (r_kval == r_kmax);

   err_peak_detect #(
      .ERR_WIDTH (ERR_WIDTH)
   ) u_peak (
      .i_clk   (fpga_clk_i),
      .i_rst_n (rst_n_i),
      .i_clr   (w_clr),
      .i_en    (w_en),
      .i_err   (error_i),
      .o_peak  (w_peak)
   );

   // Sweep sequencer with registered outputs
   always_ff @(posedge fpga_clk_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_kmax  <= '0;
         r_kval  <= '0;
         r_pll   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_found <= 1'b0;
         r_lo    <= '0;
         r_hi    <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_kmax  <= k_max_i;
                  r_kval  <= k_min_i;
                  r_found <= 1'b0;
                  r_cnt   <= '0;
                  if (k_min_i > k_max_i) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_SETTLE;
                     r_busy  <= 1'b1;
                     r_pll   <= 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               if (abort_i) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_pll   <= 1'b0;
               end else if (r_cnt == SET_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_MEASURE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_MEASURE: begin
               if (abort_i) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_pll   <= 1'b0;
               end else if (r_cnt == WIN_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_EVAL;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_EVAL: begin
               if (abort_i) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_pll   <= 1'b0;
               end else begin
                  if (w_locked) begin
                     r_found <= 1'b1;
                     r_hi    <= r_kval;
                     if (!r_found)
                        r_lo <= r_kval;
                  end
                  if (w_stop) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_pll   <= 1'b0;
                  end else begin
                     r_kval  <= r_kval + 1'b1;
                     r_state <= ST_SETTLE;
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign k_val_o      = r_kval;
   assign pll_enable_o = r_pll;
   assign busy_o       = r_busy;
   assign done_o       = r_done;
   assign found_o      = r_found;
   assign lock_lo_o    = r_lo;
   assign lock_hi_o    = r_hi;

endmodule

// File: tb/tb_lock_range_sweep.sv
// Directed bench for lock_range_sweep with short settle/window.
// Table of sweeps plus hand-written reset/ignored-start sequence.
module tb_lock_range_sweep;

   localparam int KW = 4;
   localparam int EW = 8;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic                 abort;
   logic        [KW-1:0] kmin;
   logic        [KW-1:0] kmax;
   logic signed [EW-1:0] err;
   logic        [KW-1:0] k_val;
   logic                 pll;
   logic                 busy;
   logic                 done;
   logic                 found;
   logic        [KW-1:0] lo;
   logic        [KW-1:0] hi;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   lock_range_sweep #(
      .K_WIDTH       (KW),
      .ERR_WIDTH     (EW),
      .SETTLE_CYCLES (4),
      .WINDOW_CYCLES (4),
      .LOCK_THRESH   (2)
   ) dut (
      .fpga_clk_i   (clk),
      .rst_n_i      (rst_n),
      .start_i      (start),
      .abort_i      (abort),
      .k_min_i      (kmin),
      .k_max_i      (kmax),
      .error_i      (err),
      .k_val_o      (k_val),
      .pll_enable_o (pll),
      .busy_o       (busy),
      .done_o       (done),
      .found_o      (found),
      .lock_lo_o    (lo),
      .lock_hi_o    (hi)
   );

   typedef struct {
      string name;
      int    kmin;
      int    kmax;
      int    prof;
      int    spike;
      int    abrt;
      int    e_done;
      int    e_found;
      int    e_lo;
      int    e_hi;
      int    e_kval;
      int    e_pll;
      bit    bnd;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int err_of(input int prof, input int k);
      case (prof)
         0:       return (k >= 3 && k <= 5) ? 0 : 20;
         1:       return -128;
         2:       return (k >= 2) ? 0 : 20;
         3:       return 0;
         5:       return -2;
         default: return 20;
      endcase
   endfunction

   task automatic run_vec(input vec_t v);
      int done_at;
      int pll_seen;
      done_at  = -1;
      pll_seen = 0;
      kmin  = KW'(v.kmin);
      kmax  = KW'(v.kmax);
      err   = EW'(err_of(v.prof, v.kmin));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({v.name, "_busy0"}, int'(busy), v.e_pll);
      for (int n = 0; n <= 300; n++) begin
         if (pll)
            pll_seen = 1;
         if (done) begin
            done_at = n;
            break;
         end
         abort = (n + 1 == v.abrt);
         if (n + 1 == v.spike)
            err = 8'sd3;
         else
            err = EW'(err_of(v.prof, int'(k_val)));
         tick();
      end
      abort = 1'b0;
      chk({v.name, "_done_at"}, done_at, v.e_done);
      chk({v.name, "_found"}, int'(found), v.e_found);
      chk({v.name, "_kval"}, int'(k_val), v.e_kval);
      chk({v.name, "_pll_seen"}, pll_seen, v.e_pll);
      chk({v.name, "_busy_done"}, int'(busy), 0);
      chk({v.name, "_pll_done"}, int'(pll), 0);
      if (v.bnd) begin
         chk({v.name, "_lo"}, int'(lo), v.e_lo);
         chk({v.name, "_hi"}, int'(hi), v.e_hi);
      end
      tick();
      chk({v.name, "_pulse"}, int'(done), 0);
      tick();
      tick();
      chk({v.name, "_hold_found"}, int'(found), v.e_found);
      chk({v.name, "_hold_kval"}, int'(k_val), v.e_kval);
      if (done_at < 0) begin
         rst_n = 1'b0;
         tick();
         rst_n = 1'b1;
      end
   endtask

   initial begin
      int ndone;
      vecs[0] = '{"lockwin",  1,  8, 0, -1, -1,  54, 1,  3,  5,  6, 1, 1};
      vecs[1] = '{"badrange", 9,  4, 3, -1, -1,   0, 0,  0,  0,  9, 0, 0};
      vecs[2] = '{"allneg",   0, 15, 1, -1, -1, 144, 0,  0,  0, 15, 1, 0};
      vecs[3] = '{"abort",    0, 15, 2, -1, 42,  42, 1,  2,  3,  4, 1, 1};
      vecs[4] = '{"spk_meas", 7,  7, 3,  6, -1,   9, 0,  0,  0,  7, 1, 0};
      vecs[5] = '{"spk_set",  7,  7, 3,  2, -1,   9, 1,  7,  7,  7, 1, 1};
      vecs[6] = '{"endlock", 10, 12, 3, -1, -1,  27, 1, 10, 12, 12, 1, 1};
      vecs[7] = '{"single",   5,  5, 0, -1, -1,   9, 1,  5,  5,  5, 1, 1};
      vecs[8] = '{"negtwo",   3,  4, 5, -1, -1,  18, 1,  3,  4,  4, 1, 1};

      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      kmin  = '0;
      kmax  = '0;
      err   = '0;
      tick();
      tick();
      chk("rst_kval", int'(k_val), 0);
      chk("rst_pll", int'(pll), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_found", int'(found), 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 9; i++)
         run_vec(vecs[i]);

      // Mid-sweep reset with an ignored second start
      kmin  = 4'd0;
      kmax  = 4'd15;
      err   = 8'sd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= 46; n++) begin
         start = (n == 10);
         if (n == 10) begin
            kmin = 4'd2;
            kmax = 4'd3;
         end
         err = EW'(err_of(0, int'(k_val)));
         tick();
      end
      start = 1'b0;
      chk("mid_kval", int'(k_val), 5);
      chk("mid_busy", int'(busy), 1);
      chk("mid_hi", int'(hi), 4);
      rst_n = 1'b0;
      tick();
      chk("mrst_kval", int'(k_val), 0);
      chk("mrst_pll", int'(pll), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_done", int'(done), 0);
      chk("mrst_found", int'(found), 0);
      chk("mrst_lo", int'(lo), 0);
      chk("mrst_hi", int'(hi), 0);
      rst_n = 1'b1;
      ndone = 0;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (done)
            ndone++;
      end
      chk("mrst_nodone", ndone, 0);
      chk("mrst_idle_busy", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
